// File: rtl/tb_virt_periph.sv
// tb_virt_periph: memory-mapped virtual peripheral for the core testbench.
// Provides a stdout byte FIFO, sticky pass/fail/exit status, a countdown
// timer with level IRQ and a free-running cycle counter on a 32-byte window.
`timescale 1ns/1ps
module tb_virt_periph #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          STDOUT_DEPTH = 8,
    parameter logic [31:0] PASS_MAGIC   = 32'd123456789
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        hit_o,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        stdout_valid_o,
    output logic [7:0]  stdout_data_o,
    input  logic        stdout_ready_i,
    output logic        timer_irq_o,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int PTR_W = $clog2(STDOUT_DEPTH);

    // Word index within the window (addr_i[4:2])
    localparam logic [2:0] REG_PRINT  = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_EXIT   = 3'd2;
    localparam logic [2:0] REG_TVAL   = 3'd3;
    localparam logic [2:0] REG_TCTRL  = 3'd4;
    localparam logic [2:0] REG_CYCLE  = 3'd5;
    localparam logic [2:0] REG_LEVEL  = 3'd6;

    // Stdout FIFO
    logic [7:0]       r_mem [STDOUT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Timer, cycle counter, status
    logic [31:0] r_timer;
    logic        r_en;
    logic        r_irq;
    logic [31:0] r_cycle;
    logic        r_passed;
    logic        r_failed;
    logic        r_exit_valid;
    logic [31:0] r_exit_value;

    // Response stage
    logic        r_rvalid_p1;
    logic [31:0] r_rdata_p1;

    logic [2:0]  w_reg;
    logic        w_hit;
    logic        w_full;
    logic        w_empty;
    logic        w_stall;
    logic        w_gnt;
    logic        w_wr;
    logic        w_push;
    logic        w_pop;
    logic        w_done;
    logic        w_dec;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Byte lanes 3..1 and the sub-word address bits carry no meaning here.
    assign w_unused = ^{be_i[3:1], addr_i[1:0]};

    assign w_reg   = addr_i[4:2];
    // Hit is forced low in reset so nothing is granted while state is clearing.
    assign w_hit   = ~rst_i & (addr_i[31:5] == BASE_ADDR[31:5]);
    assign w_full  = (r_count == (PTR_W+1)'(STDOUT_DEPTH));
    assign w_empty = (r_count == '0);
    // Stall uses the registered count only: a pop this cycle does not free a
    // slot for a push until the next cycle.
    assign w_stall = we_i & (w_reg == REG_PRINT) & w_full;
    assign w_gnt   = req_i & w_hit & ~w_stall;
    assign w_wr    = w_gnt & we_i;
    assign w_push  = w_wr & (w_reg == REG_PRINT) & be_i[0];
    assign w_pop   = ~w_empty & stdout_ready_i;
    assign w_done  = r_passed | r_failed | r_exit_valid;
    assign w_dec   = r_en & (r_timer != 32'd0);

    assign hit_o          = w_hit;
    assign gnt_o          = w_gnt;
    assign rvalid_o       = r_rvalid_p1;
    assign rdata_o        = r_rvalid_p1 ? r_rdata_p1 : 32'd0;
    assign stdout_valid_o = ~w_empty;
    assign stdout_data_o  = w_empty ? 8'd0 : r_mem[r_rd_ptr];
    assign timer_irq_o    = r_irq;
    assign tests_passed_o = r_passed;
    assign tests_failed_o = r_failed;
    assign exit_valid_o   = r_exit_valid;
    assign exit_value_o   = r_exit_value;

    // Read data mux for the addressed register, sampled at the grant cycle
    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            REG_TVAL:  w_rdata = r_timer;
            REG_TCTRL: w_rdata = {31'd0, r_en};
            REG_CYCLE: w_rdata = r_cycle;
            REG_LEVEL: w_rdata = 32'(r_count);
            default:   w_rdata = 32'd0;
        endcase
    end

    // Response valid: exactly one pulse the cycle after each grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid_p1 <= 1'b0;
        end else begin
            r_rvalid_p1 <= w_gnt;
        end
    end

    // Response data: read value for reads, zero for writes
    always_ff @(posedge clk_i) begin
        r_rdata_p1 <= (w_gnt & ~we_i) ? w_rdata : 32'd0;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata_i[7:0];
    end

    // Countdown timer; a bus write always overrides the decrement and the irq set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer <= 32'd0;
            r_en    <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr && w_reg == REG_TVAL) begin
                r_timer <= wdata_i;
            end else if (w_dec) begin
                r_timer <= r_timer - 32'd1;
            end
            if (w_wr && w_reg == REG_TCTRL) begin
                r_en <= wdata_i[0];
            end
            if (w_wr && (w_reg == REG_TVAL || w_reg == REG_TCTRL)) begin
                r_irq <= 1'b0;
            end else if (w_dec && r_timer == 32'd1) begin
                r_irq <= 1'b1;
            end
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Sticky test status: the first terminating write locks out later ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_passed     <= 1'b0;
            r_failed     <= 1'b0;
            r_exit_valid <= 1'b0;
            r_exit_value <= 32'd0;
        end else if (w_wr && !w_done) begin
            if (w_reg == REG_STATUS) begin
                if (wdata_i == PASS_MAGIC) begin
                    r_passed <= 1'b1;
                end else if (wdata_i == 32'd1) begin
                    r_failed <= 1'b1;
                end
            end
            if (w_reg == REG_EXIT) begin
                r_exit_valid <= 1'b1;
                r_exit_value <= wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_tb_virt_periph.sv
// Bench for tb_virt_periph: queue-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_tb_virt_periph;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
    localparam logic [31:0] MAGIC = 32'd123456789;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready = 1'b0;

    logic        hit_o, gnt_o, rvalid_o, stdout_valid_o, timer_irq_o;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] rdata_o, exit_value_o;
    logic [7:0]  stdout_data_o;

    int total = 0;
    int bad = 0;

    tb_virt_periph #(.BASE_ADDR(BASE), .STDOUT_DEPTH(DEPTH), .PASS_MAGIC(MAGIC)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .be_i(be), .wdata_i(wdata), .hit_o(hit_o), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .stdout_valid_o(stdout_valid_o),
        .stdout_data_o(stdout_data_o), .stdout_ready_i(ready),
        .timer_irq_o(timer_irq_o), .tests_passed_o(tests_passed_o),
        .tests_failed_o(tests_failed_o), .exit_valid_o(exit_valid_o),
        .exit_value_o(exit_value_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mq[$];
    logic [31:0] m_timer = 0, m_cycle = 0, m_exit_value = 0, m_rdata = 0;
    bit          m_en, m_irq, m_passed, m_failed, m_exit, m_rvalid, m_live;

    function automatic bit m_hit_f();
        return !rst && (addr[31:5] == BASE[31:5]);
    endfunction

    function automatic bit m_gnt_f();
        return req && m_hit_f() && !(we && addr[4:2] == 3'd0 && mq.size() == DEPTH);
    endfunction

    always @(posedge clk) begin : model
        bit g;
        logic [4:0] off;
        logic [31:0] rd;
        if (rst) begin
            mq.delete();
            m_timer = 0; m_en = 0; m_irq = 0; m_cycle = 0;
            m_passed = 0; m_failed = 0; m_exit = 0; m_exit_value = 0;
            m_rvalid = 0; m_rdata = 0; m_live = 1;
        end else begin
            g   = m_gnt_f();
            off = {addr[4:2], 2'b00};
            rd  = 0;
            if (g && !we) begin
                case (off)
                    5'h0C: rd = m_timer;
                    5'h10: rd = {31'd0, m_en};
                    5'h14: rd = m_cycle;
                    5'h18: rd = mq.size();
                    default: rd = 0;
                endcase
            end
            if (mq.size() > 0 && ready) void'(mq.pop_front());
            if (g && we && off == 5'h00 && be[0]) mq.push_back(wdata[7:0]);
            if (g && we && off == 5'h0C) begin
                m_timer = wdata; m_irq = 0;
            end else if (m_en && m_timer != 0) begin
                m_timer = m_timer - 1;
                if (m_timer == 0) m_irq = 1;
            end
            if (g && we && off == 5'h10) begin
                m_en = wdata[0]; m_irq = 0;
            end
            m_cycle = m_cycle + 1;
            if (g && we && !(m_passed || m_failed || m_exit)) begin
                if (off == 5'h04) begin
                    if (wdata == MAGIC) m_passed = 1;
                    else if (wdata == 32'd1) m_failed = 1;
                end
                if (off == 5'h08) begin
                    m_exit = 1; m_exit_value = wdata;
                end
            end
            m_rvalid = g;
            m_rdata  = rd;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("hit", hit_o, m_hit_f());
            chk("gnt", gnt_o, m_gnt_f());
            chk("rvalid", rvalid_o, m_rvalid);
            if (m_rvalid) chk("rdata", rdata_o, m_rdata);
            chk("stdout_valid", stdout_valid_o, mq.size() > 0);
            if (mq.size() > 0) chk("stdout_data", stdout_data_o, mq[0]);
            chk("timer_irq", timer_irq_o, m_irq);
            chk("passed", tests_passed_o, m_passed);
            chk("failed", tests_failed_o, m_failed);
            chk("exit_valid", exit_valid_o, m_exit);
            if (m_exit) chk("exit_value", exit_value_o, m_exit_value);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Starts and ends 1 time unit after a rising edge; on return the
    // response of the granted transfer is on rvalid_o/rdata_o.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd);
        bit ok;
        ok = 0;
        req = 1; we = w; addr = a; wdata = d; be = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = gnt_o;
            @(posedge clk); #1;
        end
        req = 0; we = 0;
        chk("grant_within_bound", ok, 1);
        chk("rvalid_after_grant", rvalid_o, 1);
        rd = rdata_o;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(1, BASE + off, d, 4'hF, dummy);
    endtask

    task automatic rd_reg(input logic [31:0] off, output logic [31:0] v);
        xfer(0, BASE + off, 32'd0, 4'hF, v);
    endtask

    task automatic do_reset();
        rst = 1; req = 0; addr = BASE;
        idle(2);
        @(negedge clk);
        chk("rst_ctl", {hit_o, gnt_o, rvalid_o, stdout_valid_o, timer_irq_o,
                        tests_passed_o, tests_failed_o, exit_valid_o}, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_sdata", stdout_data_o, 0);
        chk("rst_exit_value", exit_value_o, 0);
        @(posedge clk); #1;
        rst = 0; addr = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] t1, t2, v;
        bit g;
        logic [4:0] offs [10];
        offs = '{5'h00, 5'h00, 5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};

        do_reset();

        // Cycle counter: first read right after reset is 0, reads 3 cycles apart differ by 3
        rd_reg(32'h14, t1);
        idle(2);
        rd_reg(32'h14, t2);
        chk("cycle_first", t1, 32'd0);
        chk("cycle_delta", t2 - t1, 32'd3);

        // Two prints held in the FIFO, then drained in order
        ready = 0;
        wr(32'h00, 32'h48);
        wr(32'h00, 32'h69);
        rd_reg(32'h18, v);
        chk("level_two", v, 32'd2);
        ready = 1;
        @(negedge clk);
        chk("head_H", {stdout_valid_o, stdout_data_o}, {1'b1, 8'h48});
        @(posedge clk); #1;
        @(negedge clk);
        chk("head_i", {stdout_valid_o, stdout_data_o}, {1'b1, 8'h69});
        @(posedge clk); #1;
        @(negedge clk);
        chk("drained", stdout_valid_o, 0);
        @(posedge clk); #1;
        ready = 0;

        // Full FIFO stalls the 9th print until one pop has been registered
        for (int i = 0; i < DEPTH; i++) wr(32'h00, 32'h30 + i);
        rd_reg(32'h18, v);
        chk("level_full", v, DEPTH);
        req = 1; we = 1; addr = BASE; wdata = 32'h5A; be = 4'h1;
        @(negedge clk);
        chk("full_stall_a", gnt_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_stall_b", gnt_o, 0);
        @(posedge clk); #1;
        ready = 1;
        @(negedge clk);
        chk("stall_during_pop", gnt_o, 0);
        @(posedge clk); #1;
        ready = 0;
        @(negedge clk);
        chk("grant_after_pop", gnt_o, 1);
        @(posedge clk); #1;
        req = 0; we = 0;
        ready = 1;
        g = 0;
        for (int i = 0; i < 40 && !g; i++) begin
            @(negedge clk);
            g = !stdout_valid_o;
            @(posedge clk); #1;
        end
        chk("drain_bound", g, 1);
        ready = 0;

        // Timer: load 5, enable, irq exactly on the 5th following cycle
        wr(32'h0C, 32'd5);
        wr(32'h10, 32'd1);
        chk("irq_t0", timer_irq_o, 0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk("irq_countdown", timer_irq_o, (k == 5));
        end
        idle(2);
        chk("irq_held", timer_irq_o, 1);
        wr(32'h10, 32'd1);
        chk("irq_cleared", timer_irq_o, 0);
        rd_reg(32'h0C, v);
        chk("timer_zero", v, 32'd0);
        idle(3);
        chk("irq_no_rearm", timer_irq_o, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            g = gnt_o;
            @(posedge clk); #1;
            ready = (c < 450) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            if (!req || g) begin
                if ($urandom_range(0, 2) == 0) begin
                    req = 0;
                end else begin
                    logic [4:0] o;
                    o = offs[$urandom_range(0, 9)];
                    req = 1;
                    we = $urandom_range(0, 1);
                    be = 4'($urandom_range(0, 15));
                    addr = ($urandom_range(0, 9) == 0) ? (BASE + 32'h20 + o) : (BASE + o);
                    wdata = $urandom;
                    if (o == 5'h0C) wdata = $urandom_range(0, 12);
                    if (o == 5'h04 && $urandom_range(0, 7) == 0) wdata = MAGIC;
                end
            end
        end
        @(posedge clk); #1;
        req = 0; we = 0;
        ready = 0;

        // Status: pass locks out later exit and fail writes
        do_reset();
        wr(32'h04, MAGIC);
        chk("passed_set", tests_passed_o, 1);
        wr(32'h08, 32'd7);
        chk("exit_locked", exit_valid_o, 0);
        wr(32'h04, 32'd1);
        chk("fail_locked", tests_failed_o, 0);

        // Exit code, then reset in the middle of a FIFO drain
        do_reset();
        wr(32'h08, 32'h2A);
        chk("exit_valid", exit_valid_o, 1);
        chk("exit_value", exit_value_o, 32'h2A);
        ready = 0;
        wr(32'h00, 32'h41);
        wr(32'h00, 32'h42);
        wr(32'h00, 32'h43);
        ready = 1;
        idle(1);
        chk("mid_drain", stdout_valid_o, 1);
        do_reset();
        ready = 0;
        idle(2);
        chk("post_reset_fifo", stdout_valid_o, 0);
        chk("post_reset_exit", exit_valid_o, 0);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
